// File: rtl/decode_stage.sv
// LEGv8 decode stage: owns the 32-entry register file and hands a registered
// {ALU opcode, operands, destination, memory sideband} bundle to the ALU stage.
module decode_stage #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_opcode,
  output logic [DATA_W-1:0] out_inOne,
  output logic [DATA_W-1:0] out_inTwo,
  output logic [4:0]        out_rd,
  output logic              out_wr_en,
  output logic              out_mem_rd,
  output logic              out_mem_wr,
  output logic [DATA_W-1:0] out_st_data,
  output logic              out_illegal,
  input  logic              wb_en,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data
);

  localparam logic [4:0]  XZR      = 5'(NREGS - 1);

  localparam logic [3:0]  ALU_ADD  = 4'b0010;
  localparam logic [3:0]  ALU_CBZ  = 4'b0111;
  localparam logic [3:0]  ALU_SUB  = 4'b1010;
  localparam logic [3:0]  ALU_AND  = 4'b0110;
  localparam logic [3:0]  ALU_ORR  = 4'b0100;
  localparam logic [3:0]  ALU_EOR  = 4'b1001;

  localparam logic [10:0] OP_ADD   = 11'b10001011000;
  localparam logic [10:0] OP_SUB   = 11'b11001011000;
  localparam logic [10:0] OP_AND   = 11'b10001010000;
  localparam logic [10:0] OP_ORR   = 11'b10101010000;
  localparam logic [10:0] OP_EOR   = 11'b11001010000;
  localparam logic [10:0] OP_LDUR  = 11'b11111000010;
  localparam logic [10:0] OP_STUR  = 11'b11111000000;
  localparam logic [9:0]  OP_ADDI  = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI  = 10'b1101000100;
  localparam logic [7:0]  OP_CBZ   = 8'b10110100;

  // XZR reads as zero; otherwise an in-flight writeback to the same index wins.
  function automatic logic [DATA_W-1:0] read_reg(
    input logic [4:0]        idx,
    input logic [DATA_W-1:0] stored,
    input logic              wen,
    input logic [4:0]        waddr,
    input logic [DATA_W-1:0] wdata
  );
    if (idx == XZR)                  return '0;
    else if (wen && (waddr == idx))  return wdata;
    else                             return stored;
  endfunction

  function automatic logic [DATA_W-1:0] sext9(input logic signed [8:0] v);
    return {{(DATA_W-9){v[8]}}, v};
  endfunction

  function automatic logic [DATA_W-1:0] sext19(input logic signed [18:0] v);
    return {{(DATA_W-19){v[18]}}, v};
  endfunction

  logic [DATA_W-1:0] regs_q [NREGS];

  logic              vld_q;
  logic [3:0]        opc_q, opc_d;
  logic [DATA_W-1:0] one_q, one_d;
  logic [DATA_W-1:0] two_q, two_d;
  logic [4:0]        rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              mrd_q, mrd_d;
  logic              mwr_q, mwr_d;
  logic [DATA_W-1:0] st_q, st_d;
  logic              ill_q, ill_d;

  logic              accept;
  logic [DATA_W-1:0] rn_val, rm_val, rt_val;
  logic [10:0]       op11;
  logic [9:0]        op10;
  logic [7:0]        op8;
  logic signed [8:0]  dt9;
  logic signed [18:0] br19;

  assign in_ready = !reset && (!vld_q || out_ready);
  assign accept   = in_valid && in_ready;

  assign op11 = instr[31:21];
  assign op10 = instr[31:22];
  assign op8  = instr[31:24];
  assign dt9  = $signed(instr[20:12]);
  assign br19 = $signed(instr[23:5]);

  assign rn_val = read_reg(instr[9:5],   regs_q[instr[9:5]],   wb_en, wb_addr, wb_data);
  assign rm_val = read_reg(instr[20:16], regs_q[instr[20:16]], wb_en, wb_addr, wb_data);
  assign rt_val = read_reg(instr[4:0],   regs_q[instr[4:0]],   wb_en, wb_addr, wb_data);

  always_comb begin
    opc_d = '0;
    one_d = '0;
    two_d = '0;
    rd_d  = '0;
    wr_d  = 1'b0;
    mrd_d = 1'b0;
    mwr_d = 1'b0;
    st_d  = '0;
    ill_d = 1'b0;
    if (op11 == OP_ADD || op11 == OP_SUB || op11 == OP_AND ||
        op11 == OP_ORR || op11 == OP_EOR) begin
      case (op11)
        OP_ADD:  opc_d = ALU_ADD;
        OP_SUB:  opc_d = ALU_SUB;
        OP_AND:  opc_d = ALU_AND;
        OP_ORR:  opc_d = ALU_ORR;
        default: opc_d = ALU_EOR;
      endcase
      one_d = rn_val;
      two_d = rm_val;
      rd_d  = instr[4:0];
      wr_d  = 1'b1;
    end else if (op10 == OP_ADDI || op10 == OP_SUBI) begin
      opc_d = (op10 == OP_ADDI) ? ALU_ADD : ALU_SUB;
      one_d = rn_val;
      two_d = {{(DATA_W-12){1'b0}}, instr[21:10]};
      rd_d  = instr[4:0];
      wr_d  = 1'b1;
    end else if (op11 == OP_LDUR || op11 == OP_STUR) begin
      opc_d = ALU_ADD;
      one_d = rn_val;
      two_d = sext9(dt9);
      rd_d  = instr[4:0];
      if (op11 == OP_LDUR) begin
        wr_d  = 1'b1;
        mrd_d = 1'b1;
      end else begin
        mwr_d = 1'b1;
        st_d  = rt_val;
      end
    end else if (op8 == OP_CBZ) begin
      opc_d = ALU_CBZ;
      one_d = rt_val;
      two_d = sext19(br19);
      rd_d  = instr[4:0];
    end else begin
      ill_d = 1'b1;
    end
  end

  // Output bundle register: loads on accept, drains when consumed, holds on stall.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q <= 1'b0;
      opc_q <= '0;
      one_q <= '0;
      two_q <= '0;
      rd_q  <= '0;
      wr_q  <= 1'b0;
      mrd_q <= 1'b0;
      mwr_q <= 1'b0;
      st_q  <= '0;
      ill_q <= 1'b0;
    end else if (accept) begin
      vld_q <= 1'b1;
      opc_q <= opc_d;
      one_q <= one_d;
      two_q <= two_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      mrd_q <= mrd_d;
      mwr_q <= mwr_d;
      st_q  <= st_d;
      ill_q <= ill_d;
    end else if (out_ready) begin
      vld_q <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wb_en && (wb_addr != XZR)) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  assign out_valid   = vld_q;
  assign out_opcode  = opc_q;
  assign out_inOne   = one_q;
  assign out_inTwo   = two_q;
  assign out_rd      = rd_q;
  assign out_wr_en   = wr_q;
  assign out_mem_rd  = mrd_q;
  assign out_mem_wr  = mwr_q;
  assign out_st_data = st_q;
  assign out_illegal = ill_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: vector table for decode, plus hand sequences
// for bypass, stall/release and mid-operation reset.
module tb_decode_stage;

  logic        clock = 1'b0;
  logic        reset, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] instr;
  logic [3:0]  out_opcode;
  logic [31:0] out_inOne, out_inTwo, out_st_data, wb_data;
  logic [4:0]  out_rd, wb_addr;
  logic        out_wr_en, out_mem_rd, out_mem_wr, out_illegal, wb_en;

  int nchk = 0;
  int nerr = 0;

  always #5 clock = ~clock;

  decode_stage #(.DATA_W(32), .NREGS(32)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_inOne(out_inOne), .out_inTwo(out_inTwo),
    .out_rd(out_rd), .out_wr_en(out_wr_en), .out_mem_rd(out_mem_rd),
    .out_mem_wr(out_mem_wr), .out_st_data(out_st_data), .out_illegal(out_illegal),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  opc;
    logic [31:0] one;
    logic [31:0] two;
    logic [4:0]  rd;
    logic        chk_rd;
    logic        wr;
    logic        mrd;
    logic        mwr;
    logic [31:0] st;
    logic        ill;
  } vec_t;

  vec_t vecs [14];

  function automatic logic [31:0] enc_r(input logic [10:0] op, input logic [4:0] rm,
                                        input logic [4:0] rn, input logic [4:0] rd);
    return {op, rm, 6'd0, rn, rd};
  endfunction

  function automatic logic [31:0] enc_i(input logic [9:0] op, input logic [11:0] imm,
                                        input logic [4:0] rn, input logic [4:0] rd);
    return {op, imm, rn, rd};
  endfunction

  function automatic logic [31:0] enc_d(input logic [10:0] op, input logic [8:0] dt,
                                        input logic [4:0] rn, input logic [4:0] rt);
    return {op, dt, 2'b00, rn, rt};
  endfunction

  function automatic logic [31:0] enc_cb(input logic [18:0] br, input logic [4:0] rt);
    return {8'b10110100, br, rt};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    tick();
    wb_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; instr = '0; out_ready = 1'b0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;

    vecs[0]  = '{enc_r(11'b10001011000, 5'd2, 5'd1, 5'd3), 4'b0010, 32'd15, 32'd15, 5'd3, 1, 1, 0, 0, 32'd0, 0};
    vecs[1]  = '{enc_r(11'b11001011000, 5'd9, 5'd8, 5'd10), 4'b1010, 32'h0F0F00FF, 32'h00FF0F0F, 5'd10, 1, 1, 0, 0, 32'd0, 0};
    vecs[2]  = '{enc_r(11'b10001010000, 5'd9, 5'd8, 5'd11), 4'b0110, 32'h0F0F00FF, 32'h00FF0F0F, 5'd11, 1, 1, 0, 0, 32'd0, 0};
    vecs[3]  = '{enc_r(11'b10101010000, 5'd1, 5'd9, 5'd12), 4'b0100, 32'h00FF0F0F, 32'd15, 5'd12, 1, 1, 0, 0, 32'd0, 0};
    vecs[4]  = '{enc_r(11'b11001010000, 5'd8, 5'd1, 5'd13), 4'b1001, 32'd15, 32'h0F0F00FF, 5'd13, 1, 1, 0, 0, 32'd0, 0};
    vecs[5]  = '{enc_i(10'b1001000100, 12'hFFF, 5'd1, 5'd14), 4'b0010, 32'd15, 32'h00000FFF, 5'd14, 1, 1, 0, 0, 32'd0, 0};
    vecs[6]  = '{enc_i(10'b1101000100, 12'd1, 5'd2, 5'd15), 4'b1010, 32'd15, 32'd1, 5'd15, 1, 1, 0, 0, 32'd0, 0};
    vecs[7]  = '{enc_d(11'b11111000010, 9'h1F8, 5'd1, 5'd7), 4'b0010, 32'd15, 32'hFFFFFFF8, 5'd7, 1, 1, 1, 0, 32'd0, 0};
    vecs[8]  = '{enc_d(11'b11111000000, 9'h0FF, 5'd2, 5'd8), 4'b0010, 32'd15, 32'h000000FF, 5'd0, 0, 0, 0, 1, 32'h0F0F00FF, 0};
    vecs[9]  = '{enc_cb(19'd4, 5'd31), 4'b0111, 32'd0, 32'd4, 5'd0, 0, 0, 0, 0, 32'd0, 0};
    vecs[10] = '{enc_cb(19'h7FFFF, 5'd1), 4'b0111, 32'd15, 32'hFFFFFFFF, 5'd0, 0, 0, 0, 0, 32'd0, 0};
    vecs[11] = '{enc_r(11'b10101010000, 5'd31, 5'd31, 5'd4), 4'b0100, 32'd0, 32'd0, 5'd4, 1, 1, 0, 0, 32'd0, 0};
    vecs[12] = '{32'h00000000, 4'b0000, 32'd0, 32'd0, 5'd0, 0, 0, 0, 0, 32'd0, 1};
    vecs[13] = '{32'hFFFFFFFF, 4'b0000, 32'd0, 32'd0, 5'd0, 0, 0, 0, 0, 32'd0, 1};

    // Reset state
    tick(); tick();
    check("reset in_ready", in_ready, 0);
    check("reset out_valid", out_valid, 0);
    check("reset opcode", out_opcode, 0);
    check("reset inOne", out_inOne, 0);
    check("reset illegal", out_illegal, 0);
    reset = 1'b0;
    #1;
    check("post-reset in_ready", in_ready, 1);

    wb_write(5'd1, 32'd15);
    wb_write(5'd2, 32'd15);
    wb_write(5'd8, 32'h0F0F00FF);
    wb_write(5'd9, 32'h00FF0F0F);
    wb_write(5'd31, 32'd99);

    // Decode table, back-to-back with the consumer always ready
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      instr = vecs[i].instr;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check($sformatf("v%0d out_valid", i), out_valid, 1);
      check($sformatf("v%0d opcode", i), out_opcode, vecs[i].opc);
      check($sformatf("v%0d inOne", i), out_inOne, vecs[i].one);
      check($sformatf("v%0d inTwo", i), out_inTwo, vecs[i].two);
      if (vecs[i].chk_rd) check($sformatf("v%0d rd", i), out_rd, vecs[i].rd);
      check($sformatf("v%0d wr_en", i), out_wr_en, vecs[i].wr);
      check($sformatf("v%0d mem_rd", i), out_mem_rd, vecs[i].mrd);
      check($sformatf("v%0d mem_wr", i), out_mem_wr, vecs[i].mwr);
      if (vecs[i].mwr) check($sformatf("v%0d st_data", i), out_st_data, vecs[i].st);
      check($sformatf("v%0d illegal", i), out_illegal, vecs[i].ill);
    end

    // Same-cycle writeback bypass: SUB X6,X5,X5 while X5<=10
    instr = enc_r(11'b11001011000, 5'd5, 5'd5, 5'd6);
    in_valid = 1'b1; wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'd10;
    tick();
    in_valid = 1'b0; wb_en = 1'b0;
    check("bypass opcode", out_opcode, 4'b1010);
    check("bypass inOne", out_inOne, 32'd10);
    check("bypass inTwo", out_inTwo, 32'd10);
    check("bypass rd", out_rd, 5'd6);

    // XZR is never bypassed: ORR X4,X31,X31 while writing X31<=77
    instr = enc_r(11'b10101010000, 5'd31, 5'd31, 5'd4);
    in_valid = 1'b1; wb_en = 1'b1; wb_addr = 5'd31; wb_data = 32'd77;
    tick();
    in_valid = 1'b0; wb_en = 1'b0;
    check("xzr bypass inOne", out_inOne, 32'd0);
    check("xzr bypass inTwo", out_inTwo, 32'd0);

    tick();
    check("drain out_valid", out_valid, 0);

    // Stall: ADD X3,X1,X2 held while next instr waits and X1 is rewritten
    out_ready = 1'b0;
    instr = enc_r(11'b10001011000, 5'd2, 5'd1, 5'd3);
    in_valid = 1'b1;
    tick();
    instr = enc_i(10'b1101000100, 12'd1, 5'd2, 5'd15);
    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'd50;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("stall%0d in_ready", k), in_ready, 0);
      check($sformatf("stall%0d out_valid", k), out_valid, 1);
      check($sformatf("stall%0d opcode", k), out_opcode, 4'b0010);
      check($sformatf("stall%0d inOne", k), out_inOne, 32'd15);
      check($sformatf("stall%0d rd", k), out_rd, 5'd3);
      tick();
      wb_en = 1'b0;
    end
    out_ready = 1'b1;
    #1;
    check("release in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("release out_valid", out_valid, 1);
    check("release opcode", out_opcode, 4'b1010);
    check("release rd", out_rd, 5'd15);
    check("release inOne", out_inOne, 32'd15);
    tick();
    check("release no dup", out_valid, 0);

    // Reset with a bundle pending; wb during reset must be ignored
    out_ready = 1'b0;
    instr = enc_r(11'b10001011000, 5'd2, 5'd1, 5'd3);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("pre-reset out_valid", out_valid, 1);
    check("stall-time wb inOne", out_inOne, 32'd50);
    reset = 1'b1; out_ready = 1'b1;
    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'd123;
    #1;
    check("mid-reset in_ready", in_ready, 0);
    tick();
    reset = 1'b0; wb_en = 1'b0;
    check("mid-reset out_valid", out_valid, 0);
    check("mid-reset opcode", out_opcode, 0);
    check("mid-reset inOne", out_inOne, 0);
    check("mid-reset rd", out_rd, 0);
    check("mid-reset wr_en", out_wr_en, 0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("after reset out_valid", out_valid, 1);
    check("after reset X1", out_inOne, 32'd0);
    check("after reset X2", out_inTwo, 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
